// File: rtl/pin_pulse_meter.sv
// Pin pulse meter: times high/low segments of a filtered pin in ena ticks and queues them in a FIFO.
// Optional saturation timeout records are enabled by defining PULSE_METER_TIMEOUT_EN.
module pin_pulse_meter #(
  parameter int CNT_W = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       ena,
  input  logic                       level,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [CNT_W-1:0]           rd_width,
  output logic                       rd_level,
  output logic                       rd_tmo,
  output logic [$clog2(DEPTH):0]     fill,
  output logic                       overflow,
  input  logic                       clr_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {ARM, MEASURE} state_e;

  state_e            state_q;
  logic              level_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              edgeDet;

  logic              pushReq;
  logic              pushTmo;

  logic [PW-1:0]     wrPtr_q, wrPtr_d;
  logic [PW-1:0]     rdPtr_q, rdPtr_d;
  logic [PW-1:0]     fill_q, fill_d;
  logic              full, empty, pop, doPush, drop, bypass;
  logic              ovf_q;

  logic [CNT_W-1:0]  memWidth [DEPTH];
  logic              memLevel [DEPTH];

  logic              headValid_q, headValid_d;
  logic [CNT_W-1:0]  headWidth_q, headWidth_d;
  logic              headLevel_q, headLevel_d;

  assign edgeDet = (level != level_q);

  always_comb begin
    cnt_d = cnt_q;
    if (edgeDet)
      cnt_d = '0;
    else if (ena && (cnt_q != CNT_MAX))
      cnt_d = cnt_q + 1'b1;
  end

`ifdef PULSE_METER_TIMEOUT_EN
  logic tmoSent_q;
  logic tmoFire;
  logic memTmo [DEPTH];
  logic headTmo_q, headTmo_d;

  // A saturated counter in MEASURE emits a single timeout record until the next edge.
  assign tmoFire = (state_q == MEASURE) && !edgeDet && (cnt_q == CNT_MAX) && !tmoSent_q;
  assign pushReq = ((state_q == MEASURE) && edgeDet) || tmoFire;
  assign pushTmo = tmoFire;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      tmoSent_q <= 1'b0;
    else if (edgeDet)
      tmoSent_q <= 1'b0;
    else if (tmoFire)
      tmoSent_q <= 1'b1;
  end
`else
  assign pushReq = (state_q == MEASURE) && edgeDet;
  assign pushTmo = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_q <= 1'b1;
      cnt_q   <= '0;
      state_q <= ARM;
    end else begin
      level_q <= level;
      cnt_q   <= cnt_d;
      case (state_q)
        ARM:     if (edgeDet) state_q <= MEASURE;
        MEASURE: state_q <= MEASURE;
        default: state_q <= ARM;
      endcase
    end
  end

  assign empty  = (wrPtr_q == rdPtr_q);
  assign full   = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign pop    = !empty && rd_ready;
  assign doPush = pushReq && (!full || pop);
  assign drop   = pushReq && full && !pop;

  always_comb begin
    wrPtr_d = wrPtr_q + PW'(doPush);
    rdPtr_d = rdPtr_q + PW'(pop);
    fill_d  = wrPtr_d - rdPtr_d;
  end

  // The head is registered, so the incoming entry is forwarded when it lands directly at the head slot.
  assign bypass = doPush && (rdPtr_d[AW-1:0] == wrPtr_q[AW-1:0]);

  always_comb begin
    headValid_d = (fill_d != '0);
    headWidth_d = '0;
    headLevel_d = 1'b0;
    if (headValid_d) begin
      headWidth_d = bypass ? cnt_q   : memWidth[rdPtr_d[AW-1:0]];
      headLevel_d = bypass ? level_q : memLevel[rdPtr_d[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) begin
      memWidth[wrPtr_q[AW-1:0]] <= cnt_q;
      memLevel[wrPtr_q[AW-1:0]] <= level_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      fill_q      <= '0;
      headValid_q <= 1'b0;
      headWidth_q <= '0;
      headLevel_q <= 1'b0;
    end else begin
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      fill_q      <= fill_d;
      headValid_q <= headValid_d;
      headWidth_q <= headWidth_d;
      headLevel_q <= headLevel_d;
    end
  end

`ifdef PULSE_METER_TIMEOUT_EN
  always_comb begin
    headTmo_d = 1'b0;
    if (headValid_d)
      headTmo_d = bypass ? pushTmo : memTmo[rdPtr_d[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (doPush)
      memTmo[wrPtr_q[AW-1:0]] <= pushTmo;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      headTmo_q <= 1'b0;
    else
      headTmo_q <= headTmo_d;
  end

  assign rd_tmo = headTmo_q;
`else
  assign rd_tmo = pushTmo;
`endif

  // A dropped entry outranks a same-cycle clear so no overflow event is lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      ovf_q <= 1'b0;
    else if (drop)
      ovf_q <= 1'b1;
    else if (clr_ovf)
      ovf_q <= 1'b0;
  end

  assign rd_valid = headValid_q;
  assign rd_width = headWidth_q;
  assign rd_level = headLevel_q;
  assign fill     = fill_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_pin_pulse_meter.sv
// Directed testbench for pin_pulse_meter (CNT_W=4, DEPTH=4); expectations follow PULSE_METER_TIMEOUT_EN.
module tb_pin_pulse_meter;

  localparam int CNT_W = 4;
  localparam int DEPTH = 4;

  logic             clk;
  logic             reset_n;
  logic             ena;
  logic             level;
  logic             rd_valid;
  logic             rd_ready;
  logic [CNT_W-1:0] rd_width;
  logic             rd_level;
  logic             rd_tmo;
  logic [2:0]       fill;
  logic             overflow;
  logic             clr_ovf;

  int checksTotal;
  int checksPassed;

  pin_pulse_meter #(.CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .ena      (ena),
    .level    (level),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_width (rd_width),
    .rd_level (rd_level),
    .rd_tmo   (rd_tmo),
    .fill     (fill),
    .overflow (overflow),
    .clr_ovf  (clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every comparison funnels through here so the summary counts stay honest.
  task automatic checkOutput(input string tag, input int actual, input int expected);
    checksTotal++;
    if (actual == expected)
      checksPassed++;
    else
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int enaTicks, input logic newLevel, input logic popAtEdge);
    ena = 1'b1;
    repeat (enaTicks) tick();
    ena = 1'b0;
    level = newLevel;
    rd_ready = popAtEdge;
    tick();
    rd_ready = 1'b0;
  endtask

  task automatic checkHead(input string tag, input int width, input int lvl, input int tmo);
    checkOutput({tag, ".valid"}, int'(rd_valid), 1);
    checkOutput({tag, ".width"}, int'(rd_width), width);
    checkOutput({tag, ".level"}, int'(rd_level), lvl);
    checkOutput({tag, ".tmo"},   int'(rd_tmo),   tmo);
  endtask

  task automatic popOne();
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
  endtask

  int expWidth [4] = '{4, 5, 6, 2};
  int expLevel [4] = '{0, 1, 0, 0};

  initial begin
    checksTotal  = 0;
    checksPassed = 0;
    reset_n  = 1'b0;
    ena      = 1'b0;
    level    = 1'b1;
    rd_ready = 1'b0;
    clr_ovf  = 1'b0;
    repeat (3) tick();
    checkOutput("rst.valid", int'(rd_valid), 0);
    checkOutput("rst.fill", int'(fill), 0);
    checkOutput("rst.ovf", int'(overflow), 0);
    checkOutput("rst.width", int'(rd_width), 0);
    checkOutput("rst.tmo", int'(rd_tmo), 0);
    reset_n = 1'b1;
    tick();

    // First edge arms the meter; a 10-tick low segment follows.
    level = 1'b0;
    tick();
    checkOutput("arm.valid", int'(rd_valid), 0);
    ena = 1'b1;
    repeat (10) tick();
    ena = 1'b0;
    level = 1'b1;
    checkOutput("t1.preValid", int'(rd_valid), 0);
    tick();
    checkHead("t1", 10, 0, 0);
    checkOutput("t1.fill", int'(fill), 1);
    popOne();
    checkOutput("t1.popValid", int'(rd_valid), 0);
    checkOutput("t1.popFill", int'(fill), 0);
    checkOutput("t1.popWidth", int'(rd_width), 0);

    // Five segments into a four-deep FIFO; the last is dropped.
    applyStimulus(3, 1'b0, 1'b0);
    applyStimulus(4, 1'b1, 1'b0);
    applyStimulus(5, 1'b0, 1'b0);
    applyStimulus(6, 1'b1, 1'b0);
    checkOutput("t2.fill4", int'(fill), 4);
    checkOutput("t2.ovfBefore", int'(overflow), 0);
    applyStimulus(7, 1'b0, 1'b0);
    checkOutput("t2.fillFull", int'(fill), 4);
    checkOutput("t2.ovf", int'(overflow), 1);
    checkHead("t2.head", 3, 1, 0);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    checkOutput("t2.ovfClr", int'(overflow), 0);

    // Full FIFO with a pop coinciding with an edge: both accepted.
    applyStimulus(2, 1'b1, 1'b1);
    checkOutput("t3.fill", int'(fill), 4);
    checkOutput("t3.ovf", int'(overflow), 0);
    for (int i = 0; i < 4; i++) begin
      checkHead($sformatf("t3.pop%0d", i), expWidth[i], expLevel[i], 0);
      popOne();
    end
    checkOutput("t3.emptyValid", int'(rd_valid), 0);
    checkOutput("t3.emptyFill", int'(fill), 0);

    // Edge with simultaneous ena at cnt=7 reports 7 and restarts from 0.
    ena = 1'b1;
    repeat (7) tick();
    level = 1'b0;
    tick();
    ena = 1'b0;
    checkHead("t4", 7, 1, 0);
    applyStimulus(2, 1'b1, 1'b1);
    checkHead("t4.bypass", 2, 0, 0);
    checkOutput("t4.fill", int'(fill), 1);
    popOne();
    popOne();
    checkOutput("t4.popEmptyValid", int'(rd_valid), 0);
    checkOutput("t4.popEmptyFill", int'(fill), 0);

    // Long high segment saturates the 4-bit counter.
    applyStimulus(20, 1'b0, 1'b0);
`ifdef PULSE_METER_TIMEOUT_EN
    checkOutput("t5.fill", int'(fill), 2);
    checkHead("t5.tmoRec", 15, 1, 1);
    popOne();
`else
    checkOutput("t5.fill", int'(fill), 1);
`endif
    checkHead("t5.edgeRec", 15, 1, 0);
    popOne();
    checkOutput("t5.emptyFill", int'(fill), 0);

    // Asynchronous reset with three entries pending.
    applyStimulus(1, 1'b1, 1'b0);
    applyStimulus(2, 1'b0, 1'b0);
    applyStimulus(3, 1'b1, 1'b0);
    checkOutput("t6.fill3", int'(fill), 3);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("t6.rstValid", int'(rd_valid), 0);
    checkOutput("t6.rstFill", int'(fill), 0);
    checkOutput("t6.rstWidth", int'(rd_width), 0);
    tick();
    reset_n = 1'b1;
    tick();
    level = 1'b0;
    tick();
    tick();
    checkOutput("t6.armSwallow", int'(rd_valid), 0);
    applyStimulus(4, 1'b1, 1'b0);
    checkHead("t6.after", 4, 0, 0);
    checkOutput("t6.fill", int'(fill), 1);

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule

// File: doc/pin_pulse_meter.md
Name: pin_pulse_meter

Overview:
- Sits directly downstream of the GPIO pin filter. Consumes its stabilised level output and the same sample strobe.
- Measures the duration of each high and low segment in sample-strobe ticks.
- Queues each completed measurement in a small FIFO, read by the CPU-side register logic over a valid/ready handshake.
- Used for MSX joystick/paddle timing and bus-strobe width diagnostics.

Parameters:
- CNT_W, 16: width of the tick counter and of rd_width.
- DEPTH, 4: number of FIFO entries; must be a power of 2, minimum 2.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- ena  in  1  sample strobe; the same strobe that drives the pin filter
- level  in  1  filtered pin level
- rd_valid  out  1  FIFO head entry available
- rd_ready  in  1  consumer accepts the head entry; a pop occurs when rd_valid and rd_ready are both 1
- rd_width  out  CNT_W  head entry duration, in ena ticks
- rd_level  out  1  level of the measured segment
- rd_tmo  out  1  head entry is a timeout record (0 when the feature is compiled out)
- fill  out  $clog2(DEPTH)+1  number of valid entries
- overflow  out  1  sticky: an entry was dropped because the FIFO was full
- clr_ovf  in  1  clears overflow

Behaviour:
- Reset (asynchronous, reset_n low) puts the block in this state:
  - level_q=1, cnt=0, state=ARM, FIFO empty.
  - rd_valid=0, rd_width=0, rd_level=0, rd_tmo=0, fill=0, overflow=0.
- Edge detect:
  - edge = (level != level_q), evaluated every clk.
  - level_q <= level every clk.
  - ena does not gate edge detection.
- Counter:
  - On edge: cnt <= 0.
  - Otherwise, on ena: cnt <= cnt+1, saturating at 2^CNT_W-1.
  - Edge and ena in the same cycle: edge wins, so cnt <= 0 and the reported width is the pre-increment cnt.
- FSM:
  - ARM: the segment in progress is of unknown start and is not reported. On the first edge: no push, cnt cleared, go to MEASURE.
  - MEASURE: on each edge, push {rd_level=level_q, width=cnt, tmo=0}; stay in MEASURE.
  - There is no path back to ARM except reset.
- Push latency: the entry is visible at the FIFO head (rd_valid=1 if the FIFO was empty) on the cycle after the edge cycle.
- FIFO:
  - Circular buffer with read/write pointers of $clog2(DEPTH)+1 bits; full/empty are decided by the MSB compare.
  - Head outputs are registered.
  - rd_width, rd_level and rd_tmo read 0 while empty.
- Full condition:
  - Push while full with no simultaneous pop: the entry is dropped, overflow <= 1, and the FIFO contents are unchanged.
  - Push and pop in the same cycle while full: both are accepted; fill is unchanged and no overflow.
  - Push and pop in the same cycle while fill=1: the head advances to the new entry with no bubble; rd_valid stays 1.
- Empty condition: pop while empty is ignored.
- overflow:
  - Cleared by clr_ovf.
  - Set has priority over clr_ovf in the same cycle.
- fill is updated in the same cycle as the pointers and reflects the post-operation count on the next cycle.
- Reset mid-operation: all pending entries are discarded and the FSM returns to ARM.

Optional Feature:
- Macro: PULSE_METER_TIMEOUT_EN.
- Defined:
  - When cnt reaches saturation (2^CNT_W-1) in MEASURE, push exactly one record {level_q, width=2^CNT_W-1, tmo=1} and set the internal flag tmo_sent.
  - No further timeout pushes occur until the next edge.
  - The next edge clears tmo_sent and pushes its normal record with width=2^CNT_W-1 and tmo=0.
  - The timeout push obeys the same full/overflow rules as an edge push.
- Not defined: the counter saturates silently, the tmo_sent logic is absent, and rd_tmo is tied to 0.

Test Plan:
- Hold level=1 and assert reset. Drop level to 0 (first edge), wait 10 ena ticks, then raise level -> exactly one entry {rd_level=0, rd_width=10}, rd_valid rises one cycle after the rising edge, fill=1.
- Drive 5 alternating segments of 3,4,5,6,7 ticks with rd_ready=0 and DEPTH=4 -> first 4 entries retained in order, the 5th is dropped, overflow=1. Pulse clr_ovf -> overflow=0.
- FIFO full, hold rd_ready=1 and generate an edge in the same cycle as a pop -> fill stays 4, overflow stays 0, the new entry appears at the tail.
- Align an edge with an ena pulse when cnt=7 -> pushed width=7 (not 8), and cnt=0 on the next cycle.
- CNT_W=4, macro defined, hold level for 20 ticks -> one entry {width=15, tmo=1}. The next edge then gives {width=15, tmo=0}. With the macro undefined -> only the {width=15, tmo=0} entry.
- Assert reset_n low while fill=3 -> rd_valid=0 and fill=0 immediately. After release, the first edge is swallowed (ARM state).
